// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - HI/LO multiply/divide unit with countdown latency and kill support
module multdiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        dis,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_start;
  logic        is_mul;
  logic [3:0]  load_cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_start = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && !dis;
  assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign load_cnt = is_mul ? MULT_LOAD : DIV_LOAD;
  assign busy     = (count != 4'd0) || is_start;

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == OP_MFHI)      md_rdata = hi;
    else if (md_op == OP_MFLO) md_rdata = lo;
  end

  // Signed divide works on magnitudes, then restores signs: quotient truncates
  // toward zero and the remainder follows the dividend.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    abs_a  = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
    abs_b  = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
    safe_b = (rt_data == 32'd0) ? 32'd1 : rt_data;
    quo    = 32'd0;
    rem    = 32'd0;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
      OP_MULTU: {res_hi, res_lo} = {32'd0, rs_data} * {32'd0, rt_data};
      OP_DIV: begin
        if (rt_data == 32'd0) begin
          res_wr = 1'b0;
        end else begin
          quo    = abs_a / abs_b;
          rem    = abs_a % abs_b;
          res_lo = (rs_data[31] ^ rt_data[31]) ? (~quo + 32'd1) : quo;
          res_hi = rs_data[31] ? (~rem + 32'd1) : rem;
        end
      end
      OP_DIVU: begin
        res_wr = (rt_data != 32'd0);
        res_lo = rs_data / safe_b;
        res_hi = rs_data % safe_b;
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            if (load_cnt == 4'd0) begin
              if (res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
              end
            end else begin
              count <= load_cnt;
              state <= S_RUN;
            end
          end else if (!dis && md_op == OP_MTHI) begin
            hi <= rs_data;
          end else if (!dis && md_op == OP_MTLO) begin
            lo <= rs_data;
          end
        end
        S_RUN: begin
          // In-flight ops are older than any killed instruction, so dis is ignored here.
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= S_IDLE;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed table-driven bench for multdiv_unit
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        dis;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int total = 0;
  int bad   = 0;
  int run_cnt = 0;

  always #5 clk = ~clk;

  multdiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_data(rs_data), .rt_data(rt_data),
    .dis(dis), .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  // Independent run tracker used to flag start/move ops issued while the unit is busy.
  always @(posedge clk) begin
    if (!reset) begin
      run_cnt <= 0;
    end else if (run_cnt != 0) begin
      assert (!((md_op >= 4'd1) && (md_op <= 4'd6) && !dis))
        else $error("protocol violation: md_op %0d issued during run", md_op);
      run_cnt <= run_cnt - 1;
    end else if ((md_op >= 4'd1) && (md_op <= 4'd4) && !dis) begin
      run_cnt <= (md_op <= 4'd2) ? 4 : 9;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val);
    md_op = op; rs_data = val; rt_data = 32'd0; dis = 1'b0;
    tick();
    md_op = 4'd0;
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    md_op = op; rs_data = a; rt_data = b; dis = 1'b0;
    #1;
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cycles++;
      tick();
      md_op = 4'd0;
      #1;
    end
  endtask

  initial begin
    int cyc;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'h3,        32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{4'd1, 32'h80000000, 32'h80000000, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h40000000, 32'h00000000, 5};
    vecs[3] = '{4'd2, 32'h80000000, 32'h2,        32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000001, 32'h00000000, 5};
    vecs[4] = '{4'd3, 32'hFFFFFFF9, 32'h2,        32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5] = '{4'd3, 32'h7,        32'hFFFFFFFE, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000000, 32'h80000000, 10};
    vecs[7] = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8] = '{4'd4, 32'h7,        32'h0,        32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10};
    vecs[9] = '{4'd3, 32'h5,        32'h0,        32'h000000AA, 32'h000000BB, 32'h000000AA, 32'h000000BB, 10};

    reset = 1'b0; md_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0; dis = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset rdata", md_rdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      move_to(4'd5, vecs[i].pre_hi);
      move_to(4'd6, vecs[i].pre_lo);
      check($sformatf("vec%0d preload hi", i), hi, vecs[i].pre_hi);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d busy cycles", i), 32'(cyc), 32'(vecs[i].n));
      check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
    end

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    md_op = 4'd7; #1;
    check("mfhi rdata", md_rdata, 32'hFFFFFFFE);
    md_op = 4'd8; #1;
    check("mflo rdata", md_rdata, 32'h00000001);
    md_op = 4'd0; #1;
    check("none rdata", md_rdata, 32'd0);
    md_op = 4'd9; rs_data = 32'hDEADBEEF; #1;
    check("bad op busy", {31'd0, busy}, 32'd0);
    check("bad op rdata", md_rdata, 32'd0);
    tick();
    check("bad op hi", hi, 32'hFFFFFFFE);

    md_op = 4'd6; rs_data = 32'h1234; dis = 1'b1; #1;
    check("killed mtlo busy", {31'd0, busy}, 32'd0);
    tick();
    check("killed mtlo lo", lo, 32'h00000001);
    md_op = 4'd1; rs_data = 32'd2; rt_data = 32'd3; dis = 1'b1; #1;
    check("killed mult busy", {31'd0, busy}, 32'd0);
    tick();
    md_op = 4'd0; dis = 1'b0; #1;
    check("killed mult idle", {31'd0, busy}, 32'd0);
    check("killed mult hi", hi, 32'hFFFFFFFE);

    md_op = 4'd1; rs_data = 32'd2; rt_data = 32'd3; dis = 1'b0; #1;
    check("mult start busy", {31'd0, busy}, 32'd1);
    tick();
    md_op = 4'd0; dis = 1'b1; #1;
    check("mult busy under dis", {31'd0, busy}, 32'd1);
    tick();
    dis = 1'b0; #1;
    cyc = 2;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cyc++;
      tick();
    end
    check("dis pulse cycles", 32'(cyc), 32'd5);
    check("dis pulse hi", hi, 32'd0);
    check("dis pulse lo", lo, 32'd6);

    move_to(4'd5, 32'h77);
    move_to(4'd6, 32'h88);
    md_op = 4'd3; rs_data = 32'd100; rt_data = 32'd7; dis = 1'b0; #1;
    tick();
    md_op = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    repeat (12) tick();
    check("post reset busy", {31'd0, busy}, 32'd0);
    check("post reset hi", hi, 32'd0);
    check("post reset lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Execute-stage HI/LO multiply/divide unit.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX pipeline register.
- Models multi-cycle latency with a countdown and drives the busy flag into the pipeline hazard controller's MDBusy input.
- Honours the hazard controller's dis_MULTDIV kill so a flushed instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU, counting the start cycle; legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU, counting the start cycle; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- md_op  input  4  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=MFHI 8=MFLO; all other codes are treated as NONE.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- dis  input  1  from dis_MULTDIV; suppresses the start/write of the current md_op.
- busy  output  1  to MDBusy.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- md_rdata  output  32  MFHI -> hi, MFLO -> lo, otherwise 0; combinational from the registers.

Behaviour:
- Reset (reset==0 at a rising clk edge): hi=0, lo=0, count=0, pending results=0. busy=0 from the following cycle. Reset overrides any in-flight operation, and that result is discarded.
- State machine: IDLE (count==0) and RUN (count!=0).
- busy = (count!=0) | (start-type md_op in {1..4} & !dis). Busy is therefore high in the start cycle itself.
- IDLE, start op accepted (md_op 1..4, dis==0):
  - compute the 64-bit result from rs_data/rt_data;
  - latch it into pend_hi/pend_lo;
  - load count = N-1, where N is MULT_CYCLES or DIV_CYCLES;
  - if N==1, commit directly to hi/lo at this edge and stay in IDLE.
- RUN: count decrements every cycle. On the edge where count goes 1->0, hi<=pend_hi and lo<=pend_lo. busy falls on the next cycle.
- Total latency: start at edge t, busy high for cycles t..t+N-1, new HI/LO visible from cycle t+N.
- MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. MULTU: the same, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_data==0): the op is accepted and busy runs the full DIV_CYCLES, but hi/lo are left unchanged at commit.
- MTHI/MTLO in IDLE with dis==0: hi or lo <= rs_data at that edge; busy stays 0.
- dis==1: any md_op that cycle has no effect on state. An operation already in RUN is NOT aborted and commits normally, because it is older than the faulting instruction.
- md_op 1..6 arriving during RUN is a protocol violation (the hazard controller stalls these). It is ignored, and the bench flags it with an assertion.
- MFHI/MFLO during RUN return the old hi/lo, but the hazard controller stalls them, so this never occurs architecturally.
- No X propagation: all registers are explicitly reset, and md_rdata is 0 for non-read ops.

Test Plan:
- MULT: rs=0xFFFFFFFE (-2), rt=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001; MFHI then gives md_rdata=0xFFFFFFFE.
- DIV: rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU: rs=7, rt=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy for 10 cycles; hi=0x11, lo=0x22 unchanged.
- Kill and in-flight commit:
  - MTLO rs=0x1234 with dis=1 -> lo unchanged.
  - MULT 2*3 started, dis=1 pulsed at cycle 2 -> still commits lo=6, hi=0.
- Reset mid-operation: DIV started, reset=0 at cycle 4 -> next cycle busy=0, hi=0, lo=0; no later commit occurs.
